// File: rtl/dff_shift_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// dff_shift_reg : WIDTH-bit load/shift register with frame counter, busy/done
// Revision 1.0
// ---------------------------------------------------------------------------
module dff_shift_reg #(
  parameter int               WIDTH     = 48,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               MSB_FIRST = 1'b1,
  parameter bit               IDLE_SO   = 1'b1,
  localparam int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             C,
  input  logic             RN,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic             SHIFT,
  input  logic             SI,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic [CW-1:0]    CNT,
  output logic             BUSY,
  output logic             DONE
);

  logic [WIDTH-1:0] q_shifted;
  logic             so_bit;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign q_shifted = {Q[WIDTH-2:0], SI};
      assign so_bit    = Q[WIDTH-1];
    end else begin : g_lsb_first
      assign q_shifted = {SI, Q[WIDTH-1:1]};
      assign so_bit    = Q[0];
    end
  endgenerate

  // A frame is in progress exactly while bits remain; CNT is the only frame state.
  assign BUSY = (CNT != '0);
  assign SO   = BUSY ? so_bit : IDLE_SO;

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      Q    <= RESET_VAL;
      CNT  <= '0;
      DONE <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (CLR) begin
        Q   <= RESET_VAL;
        CNT <= '0;
      end else if (LOAD) begin
        Q   <= D;
        CNT <= CW'(WIDTH);
      end else if (SHIFT && BUSY) begin
        Q    <= q_shifted;
        CNT  <= CNT - CW'(1);
        DONE <= (CNT == CW'(1));
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dff_shift_reg.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for dff_shift_reg: 48-bit MSB-first and 8-bit LSB-first instances
// checked against a vector-arithmetic reference model.
module tb_dff_shift_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rn;
  int   tests = 0;
  int   fails = 0;

  // Instance A: 48-bit, MSB first, idles high
  logic        a_clr, a_load, a_shift, a_si;
  logic [47:0] a_d, a_q;
  logic [5:0]  a_cnt;
  logic        a_so, a_busy, a_done;

  // Instance B: 8-bit, LSB first, idles low, non-zero reset value
  logic        b_clr, b_load, b_shift, b_si;
  logic [7:0]  b_d, b_q;
  logic [3:0]  b_cnt;
  logic        b_so, b_busy, b_done;

  localparam logic [63:0] B_RV = 64'h3C;

  dff_shift_reg #(.WIDTH(48), .RESET_VAL(48'h0), .MSB_FIRST(1'b1), .IDLE_SO(1'b1)) u_a (
    .C(clk), .RN(rn), .CLR(a_clr), .LOAD(a_load), .SHIFT(a_shift), .SI(a_si),
    .D(a_d), .Q(a_q), .SO(a_so), .CNT(a_cnt), .BUSY(a_busy), .DONE(a_done));

  dff_shift_reg #(.WIDTH(8), .RESET_VAL(8'h3C), .MSB_FIRST(1'b0), .IDLE_SO(1'b0)) u_b (
    .C(clk), .RN(rn), .CLR(b_clr), .LOAD(b_load), .SHIFT(b_shift), .SI(b_si),
    .D(b_d), .Q(b_q), .SO(b_so), .CNT(b_cnt), .BUSY(b_busy), .DONE(b_done));

  // Reference model state
  logic [63:0] ma_q, mb_q;
  int          ma_cnt, mb_cnt;
  bit          ma_done, mb_done;

  function automatic void mstep(input int w, input bit msb, input logic [63:0] rv,
                                input bit clr, input bit load, input bit shift, input bit si,
                                input logic [63:0] d, inout logic [63:0] q,
                                inout int cnt, inout bit done);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    done = 1'b0;
    if (clr) begin
      q = rv; cnt = 0;
    end else if (load) begin
      q = d & mask; cnt = w;
    end else if (shift && cnt > 0) begin
      if (msb) q = ((q << 1) | {63'd0, si}) & mask;
      else     q = (q >> 1) | ({63'd0, si} << (w - 1));
      cnt  = cnt - 1;
      done = (cnt == 0);
    end
  endfunction

  function automatic bit model_so(input int w, input bit msb, input bit idle,
                                  input logic [63:0] q, input int cnt);
    if (cnt == 0) return idle;
    return msb ? q[w-1] : q[0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".a_q"},    64'(a_q),    ma_q);
    chk({ph, ".a_cnt"},  64'(a_cnt),  64'(ma_cnt));
    chk({ph, ".a_busy"}, 64'(a_busy), 64'(ma_cnt > 0));
    chk({ph, ".a_done"}, 64'(a_done), 64'(ma_done));
    chk({ph, ".a_so"},   64'(a_so),   64'(model_so(48, 1'b1, 1'b1, ma_q, ma_cnt)));
    chk({ph, ".b_q"},    64'(b_q),    mb_q);
    chk({ph, ".b_cnt"},  64'(b_cnt),  64'(mb_cnt));
    chk({ph, ".b_busy"}, 64'(b_busy), 64'(mb_cnt > 0));
    chk({ph, ".b_done"}, 64'(b_done), 64'(mb_done));
    chk({ph, ".b_so"},   64'(b_so),   64'(model_so(8, 1'b0, 1'b0, mb_q, mb_cnt)));
  endtask

  task automatic model_reset();
    ma_q = 64'd0; ma_cnt = 0; ma_done = 1'b0;
    mb_q = B_RV;  mb_cnt = 0; mb_done = 1'b0;
  endtask

  // One clock edge: advance the model with the applied inputs, then compare.
  task automatic tick(input string ph);
    mstep(48, 1'b1, 64'd0, a_clr, a_load, a_shift, a_si, 64'(a_d), ma_q, ma_cnt, ma_done);
    mstep(8, 1'b0, B_RV, b_clr, b_load, b_shift, b_si, 64'(b_d), mb_q, mb_cnt, mb_done);
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic idle_inputs();
    a_clr = 0; a_load = 0; a_shift = 0; a_si = 0;
    b_clr = 0; b_load = 0; b_shift = 0; b_si = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [47:0] tx_d, rx_d, hold_q;
    logic [7:0]  b_seq;
    logic [5:0]  cnt_before;
    int          shifted, cyc, pulses;

    rn = 1'b0;
    a_d = '0; b_d = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rn = 1'b1;

    // Asynchronous reset mid-cycle while a frame is running
    a_d = 48'hDEAD_BEEF_1234; a_load = 1; b_d = 8'h5A; b_load = 1;
    tick("pre_arst_load");
    idle_inputs(); a_shift = 1; a_si = 1;
    tick("pre_arst_shift");
    #2 rn = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(posedge clk);
    #1;
    rn = 1'b1;
    idle_inputs();
    tick("arst_after");

    // TX frame, MSB first
    tx_d = 48'h40_0000_0000_95;
    a_d = tx_d; a_load = 1;
    tick("tx_load");
    a_load = 0; a_shift = 1; a_si = 1;
    for (int k = 0; k < 48; k++) begin
      chk("tx_so_seq", 64'(a_so), 64'(tx_d[47-k]));
      tick("tx_shift");
    end
    chk("tx_done", 64'(a_done), 64'd1);
    chk("tx_q",    64'(a_q),    64'hFFFF_FFFF_FFFF);
    chk("tx_cnt",  64'(a_cnt),  64'd0);
    chk("tx_so",   64'(a_so),   64'd1);
    a_shift = 0;
    tick("tx_after");
    chk("tx_done_drop", 64'(a_done), 64'd0);

    // RX with a stall every third cycle
    rx_d = 48'h3F_00FF_8001_C3;
    a_d = 48'd0; a_load = 1;
    tick("rx_load");
    a_load = 0;
    shifted = 0; cyc = 0;
    while (shifted < 48) begin
      if (cyc % 3 == 2) begin
        a_shift = 0; cnt_before = a_cnt;
        tick("rx_stall");
        chk("rx_stall_cnt", 64'(a_cnt), 64'(cnt_before));
      end else begin
        a_shift = 1; a_si = rx_d[47-shifted];
        tick("rx_shift");
        shifted++;
      end
      cyc++;
    end
    chk("rx_q",    64'(a_q),    64'(rx_d));
    chk("rx_done", 64'(a_done), 64'd1);
    a_shift = 0;

    // Priority: CLR over LOAD over SHIFT
    a_d = 48'h1234_5678_9ABC; a_load = 1;
    tick("pri_load");
    a_load = 0; a_shift = 1;
    for (int k = 0; k < 38; k++) begin
      a_si = 1'($urandom);
      tick("pri_shift");
    end
    chk("pri_cnt10", 64'(a_cnt), 64'd10);
    a_clr = 1; a_load = 1; a_shift = 1; a_d = 48'hAAAA_5555_0F0F;
    tick("pri_clr");
    chk("pri_clr_q",    64'(a_q),    64'd0);
    chk("pri_clr_cnt",  64'(a_cnt),  64'd0);
    chk("pri_clr_done", 64'(a_done), 64'd0);
    a_clr = 0;
    tick("pri_loadshift");
    chk("pri_load_q",   64'(a_q),   64'hAAAA_5555_0F0F);
    chk("pri_load_cnt", 64'(a_cnt), 64'd48);

    // Abort with LOAD at CNT=5, then idle SHIFTs
    a_load = 0;
    for (int k = 0; k < 43; k++) begin
      a_si = 1'($urandom);
      tick("abort_shift");
    end
    chk("abort_cnt5", 64'(a_cnt), 64'd5);
    a_load = 1; a_shift = 0; a_d = 48'h0000_FFFF_0000;
    tick("abort_load");
    chk("abort_cnt48", 64'(a_cnt), 64'd48);
    chk("abort_done",  64'(a_done), 64'd0);
    a_load = 0; a_clr = 1;
    tick("idle_clr");
    a_clr = 0; a_shift = 1;
    hold_q = a_q;
    for (int k = 0; k < 4; k++) begin
      a_si = 1'($urandom);
      tick("idle_shift");
      chk("idle_q",   64'(a_q),   64'(hold_q));
      chk("idle_cnt", 64'(a_cnt), 64'd0);
      chk("idle_so",  64'(a_so),  64'd1);
    end
    idle_inputs();

    // LSB-first 8-bit frame
    b_d = 8'hA5; b_load = 1;
    tick("lsb_load");
    b_load = 0; b_shift = 1; b_si = 0;
    b_seq = 8'b1010_0101;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      chk("lsb_so_seq", 64'(b_so), 64'(b_seq[7-k]));
      tick("lsb_shift");
      if (b_done) pulses++;
    end
    chk("lsb_q",  64'(b_q),  64'h00);
    chk("lsb_so", 64'(b_so), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick("lsb_after");
      if (b_done) pulses++;
    end
    chk("lsb_done_pulses", 64'(pulses), 64'd1);
    idle_inputs();

    // Randomised traffic on both instances
    for (int k = 0; k < 400; k++) begin
      a_clr   = ($urandom_range(31) == 0);
      a_load  = ($urandom_range(15) == 0);
      a_shift = ($urandom_range(3) != 0);
      a_si    = 1'($urandom);
      a_d     = 48'({$urandom(), $urandom()});
      b_clr   = ($urandom_range(31) == 0);
      b_load  = ($urandom_range(11) == 0);
      b_shift = ($urandom_range(3) != 0);
      b_si    = 1'($urandom);
      b_d     = 8'($urandom);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dff_shift_reg.md
Name: dff_shift_reg

Overview:
- Parametrised successor to the single-bit DFF/DFFSR cells.
- A WIDTH-bit load/shift register with built-in bit counter, busy/done status and asynchronous active-low reset to a parameterised value.
- Serialises and deserialises SD CMD-line frames (48-bit command/response) inside the CMD path.
- Replaces hand-chained DFFSR instances and keeps all state in one synthesisable block mapped onto the cell library.

Parameters:
WIDTH, 48, register length in bits; legal range 2..255.
RESET_VAL, 0, value of Q after reset and after CLR; WIDTH bits.
MSB_FIRST, 1, 1 = shift toward MSB (SO is Q[WIDTH-1], SI enters Q[0]); 0 = shift toward LSB (SO is Q[0], SI enters Q[WIDTH-1]).
IDLE_SO, 1, value driven on SO while not BUSY (SD CMD line idles high).

Ports:
C  input  1  clock; all state updates on rising edge.
RN  input  1  reset; asynchronous, active-low; takes effect immediately, released synchronously by the caller.
CLR  input  1  synchronous clear; highest synchronous priority.
LOAD  input  1  synchronous parallel load of D; starts a frame.
SHIFT  input  1  shift enable; acts only while BUSY.
SI  input  1  serial input bit.
D  input  WIDTH  parallel load data.
Q  output  WIDTH  register contents.
SO  output  1  serial output; combinational from state.
CNT  output  CW  bits remaining in the frame, where CW = clog2(WIDTH+1).
BUSY  output  1  frame in progress.
DONE  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (RN=0, asynchronous): Q=RESET_VAL, CNT=0, BUSY=0, DONE=0, hence SO=IDLE_SO. RN low mid-frame aborts the frame; no DONE is produced.
- Synchronous priority each rising edge of C with RN=1: CLR > LOAD > SHIFT > hold.
- CLR=1: Q<=RESET_VAL, CNT<=0, BUSY<=0, DONE<=0. Any LOAD or SHIFT in the same cycle is ignored.
- LOAD=1 (CLR=0): Q<=D, CNT<=WIDTH, BUSY<=1, DONE<=0.
  - LOAD while BUSY restarts the frame; the aborted frame never asserts DONE.
  - A simultaneous SHIFT is ignored.
- SHIFT=1 with BUSY=1 (CLR=LOAD=0):
  - MSB_FIRST=1: Q<={Q[WIDTH-2:0],SI}. MSB_FIRST=0: Q<={SI,Q[WIDTH-1:1]}.
  - CNT<=CNT-1.
  - If CNT==1 before the edge: BUSY<=0 and DONE<=1 on the same edge.
- SHIFT=1 with BUSY=0: no effect on Q or CNT. Never underflows.
- Hold (no action): Q and CNT unchanged. DONE<=0, so DONE is high for exactly one cycle after the final shift.
- SO = BUSY ? (MSB_FIRST ? Q[WIDTH-1] : Q[0]) : IDLE_SO.
  - Purely combinational from registers; no input-to-output path.
  - The bit on SO during a SHIFT cycle is the bit being consumed.
- Latency:
  - LOAD to first valid SO: 1 cycle.
  - A frame of WIDTH consecutive SHIFTs completes WIDTH cycles after the LOAD edge.
  - After DONE, Q holds the WIDTH SI bits received, first-received bit at the SO end.
- Gaps in SHIFT (SHIFT=0 while BUSY) stall the frame with no state change. SD clock gating relies on this.
- Widths: CNT is CW bits, counts WIDTH down to 0, and never exceeds WIDTH. No truncation occurs.
- X-safety: with RN=0, outputs are defined regardless of other inputs.

Test Plan:
- Reset: RN=0 asynchronously mid-cycle with WIDTH=48, RESET_VAL=0 -> Q=0, CNT=0, BUSY=0, DONE=0, SO=1 before the next edge.
- TX frame, MSB_FIRST=1: LOAD D=48'h40_0000_0000_95, then 48 SHIFTs with SI=1 -> SO sequence equals D MSB-first. DONE high exactly one cycle after the 48th SHIFT edge, with BUSY=0, CNT=0, Q=48'hFFFF_FFFF_FFFF, SO=1.
- RX with stalls: LOAD D=0, then 48 SHIFTs with SHIFT=0 every third cycle and SI=bits of 48'h3F_00FF_8001_C3, MSB first -> Q=48'h3F_00FF_8001_C3 at DONE. CNT is unchanged during stall cycles.
- Priority: with BUSY=1 and CNT=10, assert CLR, LOAD and SHIFT together -> Q=RESET_VAL, CNT=0, BUSY=0, no DONE. Next, LOAD+SHIFT -> Q=D, CNT=48, no shift applied.
- Abort/idle: LOAD mid-frame at CNT=5 restarts with CNT=48 and no DONE. SHIFT with BUSY=0 for 4 cycles leaves Q and CNT unchanged and SO=IDLE_SO.
- LSB mode, WIDTH=8, MSB_FIRST=0, IDLE_SO=0: LOAD 8'hA5, then 8 SHIFTs with SI=0 -> SO sequence 1,0,1,0,0,1,0,1. DONE pulses once; after DONE, Q=8'h00 and SO=0.
